// File: rtl/wb_stage_pkg.sv
// Shared MIPS pipeline definitions: datapath sizes, load-type encodings, M/W register layout.
package mips_defs;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    typedef struct packed {
        logic          reg_write;
        logic          mem_to_reg;
        logic [2:0]    load_type;
        logic [1:0]    byte_off;
        logic [AW-1:0] write_reg;
        logic [DW-1:0] alu_out;
        logic [DW-1:0] read_data;
    } mw_t;

endpackage

// File: rtl/wb_stage_if.sv
// Mul/div result handshake into the writeback stage; producer holds fields until md_ready.
interface wb_stage_if #(
    parameter int DW = mips_defs::DW,
    parameter int AW = mips_defs::AW
);
    logic          md_valid;
    logic [AW-1:0] md_reg;
    logic [DW-1:0] md_data;
    logic          md_ready;

    modport master (output md_valid, output md_reg, output md_data, input md_ready);
    modport slave  (input md_valid, input md_reg, input md_data, output md_ready);
endinterface

// File: rtl/wb_stage_load_extract.sv
// Big-endian load lane extraction with sign/zero extension for byte and halfword loads.
// Latency: combinational.
// Backpressure: none.
module load_extract
    import mips_defs::*;
#(
    parameter int DW = mips_defs::DW
) (
    input  logic [DW-1:0] rd_word,
    input  logic [2:0]    load_type,
    input  logic [1:0]    byte_off,
    output logic [DW-1:0] result
);

    logic [7:0]  lane;
    logic [15:0] half;

    always_comb begin
        case (byte_off)
            2'd0:    lane = rd_word[31:24];
            2'd1:    lane = rd_word[23:16];
            2'd2:    lane = rd_word[15:8];
            default: lane = rd_word[7:0];
        endcase
        // Halfword loads ignore the low offset bit; misalignment is not trapped.
        half = byte_off[1] ? rd_word[15:0] : rd_word[31:16];
    end

    always_comb begin
        case (load_type)
            LD_B:    result = {{(DW-8){lane[7]}}, lane};
            LD_BU:   result = {{(DW-8){1'b0}}, lane};
            LD_H:    result = {{(DW-16){half[15]}}, half};
            LD_HU:   result = {{(DW-16){1'b0}}, half};
            default: result = rd_word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: M/W register, load extraction, RF write-port arbitration (pipeline over mul/div).
// Latency: M-stage inputs reach the RF write port 1 cycle later; md results are written the cycle they are accepted.
// Backpressure: md_ready drops while the W slot writes; after STARVE_MAX waiting cycles md_stall_req asks for a bubble.
module wb_stage
#(
    parameter int DW         = mips_defs::DW,
    parameter int AW         = mips_defs::AW,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall_W,
    input  logic          reg_write_M,
    input  logic          mem_to_reg_M,
    input  logic [2:0]    load_type_M,
    input  logic [1:0]    byte_off_M,
    input  logic [AW-1:0] write_reg_M,
    input  logic [DW-1:0] alu_out_M,
    input  logic [DW-1:0] read_data_M,
    wb_stage_if.slave     md,
    output logic          md_stall_req,
    output logic          rw,
    output logic [AW-1:0] write_add,
    output logic [DW-1:0] data_in,
    output logic          reg_write_W,
    output logic [AW-1:0] write_reg_W,
    output logic [DW-1:0] result_W
);
    import mips_defs::*;

    localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

    mw_t           mw_q;
    logic [DW-1:0] load_data;
    logic          pipe_wr;
    logic          md_xfer;
    logic [1:0]    starve_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            mw_q <= '0;
        end else if (!stall_W) begin
            mw_q <= '{reg_write:  reg_write_M,
                      mem_to_reg: mem_to_reg_M,
                      load_type:  load_type_M,
                      byte_off:   byte_off_M,
                      write_reg:  write_reg_M,
                      alu_out:    alu_out_M,
                      read_data:  read_data_M};
        end
    end

    load_extract #(.DW(DW)) u_load_extract (
        .rd_word   (mw_q.read_data),
        .load_type (mw_q.load_type),
        .byte_off  (mw_q.byte_off),
        .result    (load_data)
    );

    assign result_W    = mw_q.mem_to_reg ? load_data : mw_q.alu_out;
    assign reg_write_W = mw_q.reg_write;
    assign write_reg_W = mw_q.write_reg;
    assign pipe_wr     = mw_q.reg_write && (mw_q.write_reg != '0);

    // Pipeline owns the port; md gets it whenever the W slot is not writing.
    always_comb begin
        rw          = 1'b0;
        write_add   = '0;
        data_in     = '0;
        md.md_ready = 1'b0;
        if (!reset) begin
            if (pipe_wr) begin
                rw        = 1'b1;
                write_add = mw_q.write_reg;
                data_in   = result_W;
            end else if (md.md_valid) begin
                md.md_ready = 1'b1;
                rw          = (md.md_reg != '0);
                write_add   = md.md_reg;
                data_in     = md.md_data;
            end else begin
                md.md_ready = 1'b1;
            end
        end
    end

    assign md_xfer = md.md_valid && md.md_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!md.md_valid || md_xfer) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 2'd1;
        end
    end

    assign md_stall_req = !reset && (starve_cnt == STARVE_LIM);

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboarded bench for wb_stage: stimulus predicts each cycle's port behaviour, a negedge monitor compares.
module tb_wb_stage;
    import mips_defs::*;

    localparam int SMAX = 3;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic        reset, stall_W, reg_write_M, mem_to_reg_M;
    logic [2:0]  load_type_M;
    logic [1:0]  byte_off_M;
    logic [4:0]  write_reg_M;
    logic [31:0] alu_out_M, read_data_M;
    logic        md_stall_req, rw, reg_write_W;
    logic [4:0]  write_add, write_reg_W;
    logic [31:0] data_in, result_W;

    wb_stage_if #(.DW(32), .AW(5)) md_bus ();

    wb_stage #(.DW(32), .AW(5), .STARVE_MAX(SMAX)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_W      (stall_W),
        .reg_write_M  (reg_write_M),
        .mem_to_reg_M (mem_to_reg_M),
        .load_type_M  (load_type_M),
        .byte_off_M   (byte_off_M),
        .write_reg_M  (write_reg_M),
        .alu_out_M    (alu_out_M),
        .read_data_M  (read_data_M),
        .md           (md_bus),
        .md_stall_req (md_stall_req),
        .rw           (rw),
        .write_add    (write_add),
        .data_in      (data_in),
        .reg_write_W  (reg_write_W),
        .write_reg_W  (write_reg_W),
        .result_W     (result_W)
    );

    typedef struct {
        logic        rst;
        logic        rw;
        logic        md_ready;
        logic        stall;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        we_w;
        logic [4:0]  reg_w;
        logic [31:0] res_w;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Next-cycle stimulus and md producer state
    bit          n_rst, n_stl, n_we, n_m2r;
    logic [2:0]  n_lt;
    logic [1:0]  n_off;
    logic [4:0]  n_dest;
    logic [31:0] n_alu, n_rd;
    bit          md_pend;
    logic [4:0]  md_r;
    logic [31:0] md_d;

    // Reference view of what sits in the W slot and how long md has waited
    bit          w_we;
    logic [4:0]  w_dest;
    logic [31:0] w_res;
    int          waitc;

    function automatic logic [31:0] ref_result(input logic [31:0] word, input logic [2:0] lt,
                                               input logic [1:0] off, input logic [31:0] alu,
                                               input bit m2r);
        logic [31:0] b, h;
        if (!m2r) return alu;
        b = (word >> (8 * (3 - int'(off)))) & 32'hFF;
        h = off[1] ? (word & 32'hFFFF) : (word >> 16);
        case (lt)
            3'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return h;
            default: return word;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic m_set(input bit we, input bit m2r, input logic [2:0] lt, input logic [1:0] off,
                         input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] rd);
        n_we = we; n_m2r = m2r; n_lt = lt; n_off = off; n_dest = dest; n_alu = alu; n_rd = rd;
    endtask

    task automatic step();
        exp_t e;
        bit   pipe, xfer;
        // Hazard unit: a stall request turns the next W slot into a bubble
        if (!n_rst && waitc >= SMAX) begin
            n_we  = 1'b0;
            n_stl = 1'b0;
        end
        reset = n_rst; stall_W = n_stl; reg_write_M = n_we; mem_to_reg_M = n_m2r;
        load_type_M = n_lt; byte_off_M = n_off; write_reg_M = n_dest;
        alu_out_M = n_alu; read_data_M = n_rd;
        md_bus.md_valid = md_pend; md_bus.md_reg = md_r; md_bus.md_data = md_d;

        pipe    = w_we && (w_dest != 5'd0);
        e.rst   = n_rst;
        e.we_w  = w_we;
        e.reg_w = w_dest;
        e.res_w = w_res;
        if (n_rst) begin
            e.rw = 1'b0; e.md_ready = 1'b0; e.addr = '0; e.data = '0;
        end else if (pipe) begin
            e.rw = 1'b1; e.md_ready = 1'b0; e.addr = w_dest; e.data = w_res;
        end else if (md_pend) begin
            e.rw = (md_r != 5'd0); e.md_ready = 1'b1; e.addr = md_r; e.data = md_d;
        end else begin
            e.rw = 1'b0; e.md_ready = 1'b1; e.addr = '0; e.data = '0;
        end
        e.stall = !n_rst && (waitc >= SMAX);
        exp_q.push_back(e);

        xfer = md_pend && e.md_ready;
        if (n_rst) begin
            w_we = 1'b0; w_dest = '0; w_res = '0; waitc = 0;
        end else begin
            waitc = (md_pend && !xfer) ? ((waitc < SMAX) ? waitc + 1 : SMAX) : 0;
            if (!n_stl) begin
                w_we   = n_we;
                w_dest = n_dest;
                w_res  = ref_result(n_rd, n_lt, n_off, n_alu, n_m2r);
            end
        end
        if (xfer) md_pend = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rw", 32'(rw), 32'(e.rw));
                chk("md_ready", 32'(md_bus.md_ready), 32'(e.md_ready));
                chk("md_stall_req", 32'(md_stall_req), 32'(e.stall));
                if (!e.rst) begin
                    chk("write_add", 32'(write_add), 32'(e.addr));
                    chk("data_in", data_in, e.data);
                    chk("reg_write_W", 32'(reg_write_W), 32'(e.we_w));
                    chk("write_reg_W", 32'(write_reg_W), 32'(e.reg_w));
                    chk("result_W", result_W, e.res_w);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        w_we = 1'b0; w_dest = '0; w_res = '0; waitc = 0;
        n_stl = 1'b0;
        m_set(1'b0, 1'b0, LD_W, 2'd0, 5'd0, 32'd0, 32'd0);

        // Reset with a pending md result; it must be taken on the first free cycle
        n_rst = 1'b1; md_pend = 1'b1; md_r = 5'd12; md_d = 32'hCAFE0001;
        step(); step();
        n_rst = 1'b0;
        step();

        // Byte and halfword loads
        m_set(1'b1, 1'b1, LD_B,  2'd1, 5'd9,  32'hDEAD0000, 32'h12F45678); step();
        m_set(1'b1, 1'b1, LD_BU, 2'd1, 5'd9,  32'hDEAD0000, 32'h12F45678); step();
        m_set(1'b1, 1'b1, LD_H,  2'd2, 5'd10, 32'hDEAD0000, 32'h1234ABCD); step();
        m_set(1'b1, 1'b1, LD_HU, 2'd3, 5'd10, 32'hDEAD0000, 32'h1234ABCD); step();
        m_set(1'b1, 1'b1, LD_B,  2'd3, 5'd11, 32'hDEAD0000, 32'h000000FF); step();
        m_set(1'b1, 1'b1, LD_W,  2'd2, 5'd11, 32'hDEAD0000, 32'h89ABCDEF); step();

        // Starvation: pipeline writes r5 every cycle while md waits on r7
        m_set(1'b1, 1'b0, LD_W, 2'd0, 5'd5, 32'h00000050, 32'd0); step();
        md_pend = 1'b1; md_r = 5'd7; md_d = 32'h0BADF00D;
        for (int i = 0; i < 7; i++) begin
            m_set(1'b1, 1'b0, LD_W, 2'd0, 5'd5, 32'h00000051 + 32'(i), 32'd0);
            step();
        end

        // r0 destinations never write; md to r0 still handshakes
        m_set(1'b1, 1'b0, LD_W, 2'd0, 5'd0, 32'h11111111, 32'd0); step();
        m_set(1'b0, 1'b0, LD_W, 2'd0, 5'd0, 32'd0, 32'd0);
        md_pend = 1'b1; md_r = 5'd0; md_d = 32'h22222222;
        step(); step();

        // Held W write under stall_W while M changes
        m_set(1'b1, 1'b0, LD_W, 2'd0, 5'd3, 32'h33333333, 32'd0); step();
        n_stl = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_set(1'b1, 1'b0, LD_W, 2'd0, 5'd4, $urandom, 32'd0);
            step();
        end
        n_stl = 1'b0;
        m_set(1'b0, 1'b0, LD_W, 2'd0, 5'd0, 32'd0, 32'd0); step();

        // Reset while md is waiting
        m_set(1'b1, 1'b0, LD_W, 2'd0, 5'd6, 32'h66666666, 32'd0); step();
        md_pend = 1'b1; md_r = 5'd8; md_d = 32'h88888888;
        step();
        n_rst = 1'b1; step();
        n_rst = 1'b0;
        m_set(1'b0, 1'b0, LD_W, 2'd0, 5'd0, 32'd0, 32'd0); step(); step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            n_rst = ($urandom_range(0, 99) == 0);
            n_stl = ($urandom_range(0, 4) == 0);
            m_set($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom, $urandom);
            if (!md_pend && $urandom_range(0, 2) == 0) begin
                md_pend = 1'b1;
                md_r    = 5'($urandom_range(0, 31));
                md_d    = $urandom;
            end
            step();
        end

        n_rst = 1'b0; n_stl = 1'b0;
        m_set(1'b0, 1'b0, LD_W, 2'd0, 5'd0, 32'd0, 32'd0);
        step(); step();
        repeat (2) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
